alu_issue_stage: RTL and testbench

- Front end that drives the RV32I ALU. Accepts an instruction word plus register-file read data, decodes OP (0110011) and OP-IMM (0010011) instructions, and produces `alu_op`, `op_a`, `op_b` and `rd`.
- Results leave through a registered valid/ready pipeline stage with a 2-entry skid buffer, so `o_ready` is a pure flop output.
- Sits between the register-read stage and the ALU/writeback stage.

---
 rtl/alu_issue_stage.sv | 155 +++++++++++++++
 tb/tb_alu_issue_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I OP/OP-IMM decode feeding the ALU through a 2-entry skid buffer
module alu_issue_stage #(
  parameter int XLEN       = 32,
  parameter int SKID_DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [3:0]      o_alu_op,
  output logic [XLEN-1:0] o_op_a,
  output logic [XLEN-1:0] o_op_b,
  output logic [4:0]      o_rd,
  output logic            o_illegal
);

  localparam int W = 1 + 4 + 2 * XLEN + 5;
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  generate
    if (SKID_DEPTH != 2) begin : g_bad_depth
      $error("alu_issue_stage supports SKID_DEPTH == 2 only");
    end
  endgenerate

  function automatic logic [3:0] alu_map(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_map = 4'd0;
      3'b001:  alu_map = 4'd7;
      3'b010:  alu_map = 4'd2;
      3'b011:  alu_map = 4'd3;
      3'b100:  alu_map = 4'd4;
      3'b101:  alu_map = 4'd8;
      3'b110:  alu_map = 4'd5;
      default: alu_map = 4'd6;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            dec_illegal;
  logic [3:0]      dec_alu;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [4:0]      dec_rd;
  logic [W-1:0]    new_entry;
  logic            unused_rs1_field;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  // Operand A comes from read data, so the rs1 field itself is not needed here.
  assign unused_rs1_field = ^i_instr[19:15];

  always_comb begin
    dec_illegal = 1'b0;
    dec_alu     = alu_map(funct3);
    dec_a       = i_rs1_data;
    dec_b       = i_rs2_data;
    dec_rd      = i_instr[11:7];
    if (opcode == OPC_OP) begin
      if (funct3 == 3'b000 || funct3 == 3'b101) begin
        if (funct7 == F7_ALT)       dec_alu = (funct3 == 3'b000) ? 4'd1 : 4'd9;
        else if (funct7 != F7_ZERO) dec_illegal = 1'b1;
      end else if (funct7 != F7_ZERO) begin
        dec_illegal = 1'b1;
      end
    end else if (opcode == OPC_IMM) begin
      if (funct3 == 3'b001 || funct3 == 3'b101) begin
        dec_b = {{(XLEN-5){1'b0}}, i_instr[24:20]};
        if (funct3 == 3'b101 && funct7 == F7_ALT) dec_alu = 4'd9;
        else if (funct7 != F7_ZERO)               dec_illegal = 1'b1;
      end else begin
        dec_b = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
      end
    end else begin
      dec_illegal = 1'b1;
    end
    if (dec_illegal) begin
      dec_alu = 4'd0;
      dec_a   = '0;
      dec_b   = '0;
      dec_rd  = 5'd0;
    end
  end

  assign new_entry = {dec_illegal, dec_alu, dec_a, dec_b, dec_rd};

  logic         v0, v1, v0_n, v1_n, ready_q;
  logic [W-1:0] d0, d1, d0_n, d1_n;
  logic         accept, drain;

  assign accept = i_valid & ready_q;
  assign drain  = v0 & i_ready;

  // Entry 0 is the output register; entry 1 only fills when entry 0 is stuck.
  always_comb begin
    v0_n = v0;
    v1_n = v1;
    d0_n = d0;
    d1_n = d1;
    if (i_flush) begin
      v0_n = 1'b0;
      v1_n = 1'b0;
    end else if (v1) begin
      if (drain) begin
        d0_n = d1;
        v1_n = 1'b0;
      end
    end else if (v0) begin
      if (drain && accept) begin
        d0_n = new_entry;
      end else if (drain) begin
        v0_n = 1'b0;
      end else if (accept) begin
        d1_n = new_entry;
        v1_n = 1'b1;
      end
    end else if (accept) begin
      d0_n = new_entry;
      v0_n = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v0      <= 1'b0;
      v1      <= 1'b0;
      d0      <= '0;
      d1      <= '0;
      ready_q <= 1'b1;
    end else begin
      v0      <= v0_n;
      v1      <= v1_n;
      d0      <= d0_n;
      d1      <= d1_n;
      ready_q <= ~v1_n;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = v0;
  assign {o_illegal, o_alu_op, o_op_a, o_op_b, o_rd} = d0;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_valid, i_ready;
  logic        o_ready, o_valid, o_illegal;
  logic [31:0] i_instr, i_rs1_data, i_rs2_data, o_op_a, o_op_b;
  logic [3:0]  o_alu_op;
  logic [4:0]  o_rd;
  int          checks = 0;
  int          errors = 0;

  alu_issue_stage #(.XLEN(32), .SKID_DEPTH(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_instr(i_instr),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_alu_op(o_alu_op),
    .o_op_a(o_op_a), .o_op_b(o_op_b), .o_rd(o_rd), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    i_valid    = v;
    i_instr    = ins;
    i_rs1_data = a;
    i_rs2_data = b;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] alu, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input logic ill);
    check({tag, ".valid"}, 64'(o_valid), 64'd1);
    check({tag, ".alu"}, 64'(o_alu_op), 64'(alu));
    check({tag, ".op_a"}, 64'(o_op_a), 64'(a));
    check({tag, ".op_b"}, 64'(o_op_b), 64'(b));
    check({tag, ".rd"}, 64'(o_rd), 64'(rd));
    check({tag, ".illegal"}, 64'(o_illegal), 64'(ill));
  endtask

  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] SRAI = 32'h4043D313;

  // instr, rs1, rs2, exp alu, exp op_a, exp op_b, exp rd, exp illegal
  localparam int NV = 19;
  logic [31:0] v_ins [NV] = '{32'h402081B3, 32'hFFF00293, 32'h4043D313, 32'h02009093, 32'h002091B3,
                              32'h0020A1B3, 32'h0020B1B3, 32'h0020C1B3, 32'h0020D1B3, 32'h4020D1B3,
                              32'h0020E1B3, 32'h0020F1B3, 32'h022081B3, 32'h402091B3, 32'h7FF0E293,
                              32'h000012B7, 32'h0040D313, 32'h6040D313, 32'h8000C293};
  logic [31:0] v_rs1 [NV] = '{32'd10, 32'd0, 32'h80000000, 32'd1, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5,
                              32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'h1234, 32'd5, 32'd9};
  logic [31:0] v_rs2 [NV] = '{32'd3, 32'd9, 32'd9, 32'd2, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7,
                              32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7};
  logic [3:0]  e_alu [NV] = '{4'd1, 4'd0, 4'd9, 4'd0, 4'd7, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9,
                              4'd5, 4'd6, 4'd0, 4'd0, 4'd5, 4'd0, 4'd8, 4'd0, 4'd4};
  logic [31:0] e_a   [NV] = '{32'd10, 32'd0, 32'h80000000, 32'd0, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5,
                              32'd5, 32'd5, 32'd5, 32'd0, 32'd0, 32'd5, 32'd0, 32'h1234, 32'd0, 32'd9};
  logic [31:0] e_b   [NV] = '{32'd3, 32'hFFFFFFFF, 32'd4, 32'd0, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7,
                              32'd7, 32'd7, 32'd7, 32'd0, 32'd0, 32'h7FF, 32'd0, 32'd4, 32'd0, 32'hFFFFF800};
  logic [4:0]  e_rd  [NV] = '{5'd3, 5'd5, 5'd6, 5'd0, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3,
                              5'd3, 5'd3, 5'd0, 5'd0, 5'd5, 5'd0, 5'd6, 5'd0, 5'd5};
  logic        e_ill [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    i_rst_n = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    check("rst.valid", 64'(o_valid), 64'd0);
    check("rst.ready", 64'(o_ready), 64'd1);
    check("rst.data", 64'({o_alu_op, o_op_a, o_op_b, o_rd, o_illegal}), 64'd0);
    i_rst_n = 1'b1;
    step();

    // single ADD, then a back-to-back decode sweep with no bubbles
    i_ready = 1'b1;
    drive(1'b1, ADD, 32'd5, 32'd7);
    step();
    expect_out("add", 4'd0, 32'd5, 32'd7, 5'd3, 1'b0);
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, v_ins[i], v_rs1[i], v_rs2[i]);
      step();
      expect_out($sformatf("vec%0d", i), e_alu[i], e_a[i], e_b[i], e_rd[i], e_ill[i]);
      check($sformatf("vec%0d.ready", i), 64'(o_ready), 64'd1);
    end
    i_valid = 1'b0;
    step();
    check("idle.valid", 64'(o_valid), 64'd0);

    // back-pressure: third push is held until the skid entry frees
    i_ready = 1'b0;
    drive(1'b1, ADD, 32'h11, 32'd0);
    step();
    expect_out("bp.a0", 4'd0, 32'h11, 32'd0, 5'd3, 1'b0);
    check("bp.ready0", 64'(o_ready), 64'd1);
    drive(1'b1, ADD, 32'h22, 32'd0);
    step();
    expect_out("bp.a1", 4'd0, 32'h11, 32'd0, 5'd3, 1'b0);
    check("bp.ready1", 64'(o_ready), 64'd0);
    drive(1'b1, ADD, 32'h33, 32'd0);
    step();
    expect_out("bp.a2", 4'd0, 32'h11, 32'd0, 5'd3, 1'b0);
    check("bp.ready2", 64'(o_ready), 64'd0);
    i_ready = 1'b1;
    step();
    expect_out("bp.b", 4'd0, 32'h22, 32'd0, 5'd3, 1'b0);
    check("bp.ready3", 64'(o_ready), 64'd1);
    step();
    expect_out("bp.c", 4'd0, 32'h33, 32'd0, 5'd3, 1'b0);
    i_valid = 1'b0;
    step();
    check("bp.empty", 64'(o_valid), 64'd0);

    // simultaneous accept and drain with one entry full
    drive(1'b1, ADD, 32'h44, 32'd1);
    step();
    expect_out("sd.d", 4'd0, 32'h44, 32'd1, 5'd3, 1'b0);
    drive(1'b1, ADD, 32'h55, 32'd2);
    step();
    expect_out("sd.e", 4'd0, 32'h55, 32'd2, 5'd3, 1'b0);
    check("sd.ready_e", 64'(o_ready), 64'd1);
    drive(1'b1, ADD, 32'h66, 32'd3);
    step();
    expect_out("sd.f", 4'd0, 32'h66, 32'd3, 5'd3, 1'b0);
    check("sd.ready_f", 64'(o_ready), 64'd1);
    i_valid = 1'b0;
    step();
    check("sd.empty", 64'(o_valid), 64'd0);

    // flush with both entries full and a concurrent input handshake
    i_ready = 1'b0;
    drive(1'b1, ADD, 32'h77, 32'd0);
    step();
    drive(1'b1, ADD, 32'h88, 32'd0);
    step();
    check("fl.full_ready", 64'(o_ready), 64'd0);
    check("fl.full_op_a", 64'(o_op_a), 64'h77);
    i_flush = 1'b1;
    drive(1'b1, ADD, 32'h99, 32'd0);
    step();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("fl.valid", 64'(o_valid), 64'd0);
    check("fl.ready", 64'(o_ready), 64'd1);
    i_ready = 1'b1;
    step();
    check("fl.nothing", 64'(o_valid), 64'd0);

    // asynchronous reset in the middle of a stall
    i_ready = 1'b0;
    drive(1'b1, SRAI, 32'h80000000, 32'd0);
    step();
    drive(1'b1, SRAI, 32'h80000000, 32'd0);
    step();
    check("ar.pre_ready", 64'(o_ready), 64'd0);
    check("ar.pre_alu", 64'(o_alu_op), 64'd9);
    i_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    check("ar.valid", 64'(o_valid), 64'd0);
    check("ar.ready", 64'(o_ready), 64'd1);
    check("ar.data", 64'({o_alu_op, o_op_a, o_op_b, o_rd, o_illegal}), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step();
    check("ar.after", 64'(o_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
